// File: rtl/hex_display_pkg.sv
// Seven-segment constants and nibble decode shared by the hex display mux.
package hex_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h67;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high segments, bit0 = a ... bit6 = g.
    function automatic logic [6:0] hex7seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex7seg_enc.sv
// Combinational single-digit hex to seven-segment encoder.
module hex7seg_enc
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    assign seg_c = hex7seg(nibble);

endmodule

// File: rtl/hex_display_mux.sv
// Multi-channel seven-segment display controller with auto/manual rotation and error blink.
// Optional leading-zero blanking is enabled by defining LZ_BLANK_EN.
module hex_display_mux
    import hex_display_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned BLINK_CYCLES = 25_000_000,
    localparam int unsigned CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned VW          = 4 * DIGITS,
    localparam int unsigned SW          = 7 * DIGITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [CW-1:0] ld_ch,
    input  logic [VW-1:0] ld_data,
    input  logic          ld_err,
    input  logic          freeze,
    input  logic          auto_mode,
    input  logic          step,
    output logic [SW-1:0] seg_out,
    output logic [CW-1:0] ch_shown
);

    localparam int unsigned DWW = $clog2(DWELL_CYCLES);
    localparam int unsigned BLW = $clog2(BLINK_CYCLES);

`ifdef LZ_BLANK_EN
    localparam logic [SW-1:0] SEG_RST = SW'(SEG_0);
`else
    localparam logic [SW-1:0] SEG_RST = {DIGITS{SEG_0}};
`endif

    logic [VW-1:0]       bank [CHANNELS];
    logic [CHANNELS-1:0] err;
    logic [CW-1:0]       sel;
    logic [DWW-1:0]      dwell_cnt;
    logic [BLW-1:0]      blink_cnt;
    logic                blink_off;
    logic                step_q;

    logic          ld_fire_c;
    logic          ld_hit_c;
    logic          dwell_tc_c;
    logic          blink_tc_c;
    logic          advance_c;
    logic [CW-1:0] sel_next_c;
    logic [VW-1:0] view_c;
    logic [6:0]    enc_c [DIGITS];
    logic [SW-1:0] seg_next_c;

    assign ld_ready   = rst & ~freeze;
    assign ld_fire_c  = ld_valid & ld_ready;
    assign ld_hit_c   = ld_fire_c && (32'(ld_ch) < CHANNELS);
    assign dwell_tc_c = (dwell_cnt == DWW'(DWELL_CYCLES - 1));
    assign blink_tc_c = (blink_cnt == BLW'(BLINK_CYCLES - 1));
    assign advance_c  = ~freeze & (auto_mode ? dwell_tc_c : (step & ~step_q));
    assign sel_next_c = (sel == CW'(CHANNELS - 1)) ? '0 : sel + CW'(1);
    assign view_c     = bank[sel];

    // Display value bank; out-of-range channels complete the handshake but write nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                bank[i] <= '0;
            end
            err <= '0;
        end else if (ld_hit_c) begin
            bank[ld_ch] <= ld_data;
            err[ld_ch]  <= ld_err;
        end
    end

    // Sequencer and blink timer; dwell is held at zero in manual mode so a mode change restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel       <= '0;
            dwell_cnt <= '0;
            blink_cnt <= '0;
            blink_off <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            step_q <= step;
            if (!auto_mode || dwell_tc_c) begin
                dwell_cnt <= '0;
            end else begin
                dwell_cnt <= dwell_cnt + DWW'(1);
            end
            if (advance_c) begin
                sel <= sel_next_c;
            end
            if (advance_c || !err[sel]) begin
                blink_cnt <= '0;
                blink_off <= 1'b0;
            end else if (blink_tc_c) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + BLW'(1);
            end
        end
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_enc
        hex7seg_enc u_enc (
            .nibble (view_c[4*g +: 4]),
            .seg_c  (enc_c[g])
        );
    end

    // Assemble the digit row, applying optional leading-zero blanking and the blink.
`ifdef LZ_BLANK_EN
    int unsigned msd_c;
    always_comb begin
        msd_c      = 0;
        seg_next_c = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (view_c[4*d +: 4] != 4'h0) begin
                msd_c = d;
            end
        end
        for (int unsigned d = 0; d < DIGITS; d++) begin
            seg_next_c[7*d +: 7] = (d <= msd_c) ? enc_c[d] : SEG_BLANK;
        end
        if (blink_off) begin
            seg_next_c = '0;
        end
    end
`else
    always_comb begin
        seg_next_c = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            seg_next_c[7*d +: 7] = enc_c[d];
        end
        if (blink_off) begin
            seg_next_c = '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_out  <= SEG_RST;
            ch_shown <= '0;
        end else begin
            seg_out  <= seg_next_c;
            ch_shown <= sel;
        end
    end

endmodule

// File: tb/tb_hex_display_mux.sv
// Directed bench for hex_display_mux with 4 digits, 3 channels, dwell 8, blink 4.
module tb_hex_display_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [1:0]  ld_ch;
    logic [15:0] ld_data;
    logic        ld_err;
    logic        freeze;
    logic        auto_mode;
    logic        step;
    logic [27:0] seg_out;
    logic [1:0]  ch_shown;

    int checks   = 0;
    int failures = 0;

    localparam logic [27:0] EXP_12AF = {7'h06, 7'h5B, 7'h77, 7'h71};
    localparam logic [27:0] EXP_3456 = {7'h4F, 7'h66, 7'h6D, 7'h7D};
    localparam logic [27:0] EXP_789C = {7'h07, 7'h7F, 7'h67, 7'h39};
    localparam logic [27:0] EXP_DARK = 28'h0;
`ifdef LZ_BLANK_EN
    localparam logic [27:0] EXP_RST  = {7'h00, 7'h00, 7'h00, 7'h3F};
    localparam logic [27:0] EXP_0005 = {7'h00, 7'h00, 7'h00, 7'h6D};
`else
    localparam logic [27:0] EXP_RST  = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [27:0] EXP_0005 = {7'h3F, 7'h3F, 7'h3F, 7'h6D};
`endif

    hex_display_mux #(
        .DIGITS       (4),
        .CHANNELS     (3),
        .DWELL_CYCLES (8),
        .BLINK_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_ch     (ld_ch),
        .ld_data   (ld_data),
        .ld_err    (ld_err),
        .freeze    (freeze),
        .auto_mode (auto_mode),
        .step      (step),
        .seg_out   (seg_out),
        .ch_shown  (ch_shown)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; ld_valid = 1'b0; ld_ch = 2'd0; ld_data = 16'h0; ld_err = 1'b0;
        freeze = 1'b0; auto_mode = 1'b0; step = 1'b0;
        repeat (3) tick();
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_ch", 32'(ch_shown), 32'd0);
        check("rst_seg", 32'(seg_out), 32'(EXP_RST));
        rst = 1'b1;
        tick();
        check("ready_after_rst", 32'(ld_ready), 32'd1);

        // Fill the three channels in manual mode.
        ld_valid = 1'b1; ld_ch = 2'd0; ld_data = 16'h12AF;
        tick();
        check("load_latency", 32'(seg_out), 32'(EXP_RST));
        ld_ch = 2'd1; ld_data = 16'h3456;
        tick();
        check("load_ch0_seg", 32'(seg_out), 32'(EXP_12AF));
        ld_ch = 2'd2; ld_data = 16'h789C;
        tick();
        ld_valid = 1'b0;
        tick();
        check("manual_idle_ch", 32'(ch_shown), 32'd0);

        // Held step gives exactly one advance.
        step = 1'b1;
        tick();
        check("step_latency", 32'(ch_shown), 32'd0);
        repeat (4) tick();
        check("step_held_ch", 32'(ch_shown), 32'd1);
        check("step_held_seg", 32'(seg_out), 32'(EXP_3456));
        step = 1'b0;
        tick();
        check("step_release_ch", 32'(ch_shown), 32'd1);
        pulse();
        check("pulse_ch2", 32'(ch_shown), 32'd2);
        check("pulse_ch2_seg", 32'(seg_out), 32'(EXP_789C));
        pulse();
        check("pulse_wrap", 32'(ch_shown), 32'd0);
        check("pulse_wrap_seg", 32'(seg_out), 32'(EXP_12AF));

        freeze = 1'b1;
        #1;
        check("freeze_ready", 32'(ld_ready), 32'd0);
        pulse();
        check("freeze_manual_hold", 32'(ch_shown), 32'd0);
        freeze = 1'b0;

        // Auto rotation: sel moves at edge 8, visible at edge 9.
        auto_mode = 1'b1;
        repeat (8) tick();
        check("auto_before_8", 32'(ch_shown), 32'd0);
        tick();
        check("auto_ch1", 32'(ch_shown), 32'd1);
        check("auto_ch1_seg", 32'(seg_out), 32'(EXP_3456));
        repeat (7) tick();
        check("auto_before_16", 32'(ch_shown), 32'd1);
        tick();
        check("auto_ch2", 32'(ch_shown), 32'd2);
        repeat (8) tick();
        check("auto_wrap", 32'(ch_shown), 32'd0);

        freeze = 1'b1; ld_valid = 1'b1; ld_ch = 2'd1; ld_data = 16'hFFFF; ld_err = 1'b1;
        #1;
        check("auto_freeze_ready", 32'(ld_ready), 32'd0);
        repeat (20) tick();
        check("auto_freeze_hold", 32'(ch_shown), 32'd0);
        freeze = 1'b0; auto_mode = 1'b0; ld_valid = 1'b0; ld_err = 1'b0;
        tick();
        pulse();
        check("frozen_load_dropped", 32'(seg_out), 32'(EXP_3456));
        repeat (6) tick();
        check("frozen_err_dropped", 32'(seg_out), 32'(EXP_3456));
        pulse();
        pulse();
        check("back_to_ch0", 32'(ch_shown), 32'd0);

        // Error blink on the shown channel, 4-cycle phases.
        ld_valid = 1'b1; ld_ch = 2'd0; ld_data = 16'h12AF; ld_err = 1'b1;
        tick();
        ld_valid = 1'b0;
        check("blink_L0", 32'(seg_out), 32'(EXP_12AF));
        repeat (4) tick();
        check("blink_L4_on", 32'(seg_out), 32'(EXP_12AF));
        tick();
        check("blink_L5_off", 32'(seg_out), 32'(EXP_DARK));
        repeat (3) tick();
        check("blink_L8_off", 32'(seg_out), 32'(EXP_DARK));
        tick();
        check("blink_L9_on", 32'(seg_out), 32'(EXP_12AF));
        repeat (3) tick();
        check("blink_L12_on", 32'(seg_out), 32'(EXP_12AF));
        tick();
        check("blink_L13_off", 32'(seg_out), 32'(EXP_DARK));
        ld_valid = 1'b1; ld_err = 1'b0;
        tick();
        ld_valid = 1'b0;
        repeat (2) tick();
        check("blink_cleared", 32'(seg_out), 32'(EXP_12AF));
        repeat (6) tick();
        check("blink_stays_on", 32'(seg_out), 32'(EXP_12AF));

        // Out-of-range channel: handshake completes, nothing stored.
        ld_valid = 1'b1; ld_ch = 2'd3; ld_data = 16'hFFFF; ld_err = 1'b1;
        #1;
        check("drop_ready", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0; ld_err = 1'b0;
        repeat (6) tick();
        check("drop_ch0", 32'(seg_out), 32'(EXP_12AF));
        pulse();
        check("drop_ch1", 32'(seg_out), 32'(EXP_3456));
        pulse();
        check("drop_ch2", 32'(seg_out), 32'(EXP_789C));
        pulse();

        ld_valid = 1'b1; ld_ch = 2'd0; ld_data = 16'h0005;
        tick();
        ld_valid = 1'b0;
        tick();
        check("value_0005", 32'(seg_out), 32'(EXP_0005));

        // Load into the next channel on the same edge as the advance.
        pulse();
        step = 1'b1; ld_valid = 1'b1; ld_ch = 2'd2; ld_data = 16'h12AF;
        tick();
        step = 1'b0; ld_valid = 1'b0;
        tick();
        check("load_adv_ch", 32'(ch_shown), 32'd2);
        check("load_adv_seg", 32'(seg_out), 32'(EXP_12AF));

        // Asynchronous reset mid-operation clears everything.
        rst = 1'b0;
        #1;
        check("midrst_ch", 32'(ch_shown), 32'd0);
        check("midrst_seg", 32'(seg_out), 32'(EXP_RST));
        check("midrst_ready", 32'(ld_ready), 32'd0);
        tick();
        rst = 1'b1;
        pulse();
        check("post_rst_ch", 32'(ch_shown), 32'd1);
        check("post_rst_bank", 32'(seg_out), 32'(EXP_RST));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
